mux_n_pipe: RTL
===============

MUX_N_PIPE -- requirements
Module: mux_n_pipe

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 64, the bit width of each data word.
REQ-002 The block SHALL have parameter NUM_IN, default 4, the number of input words (legal range 2..16).
REQ-003 The block SHALL have parameter SEL_W, default 2, the select width, with 2^SEL_W >= NUM_IN.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_data, input, NUM_IN*WIDTH bits: word k occupies bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_sel, input, SEL_W bits: index of the word to capture.
REQ-008 The block SHALL have port in_valid, input, 1 bit: the upstream beat is present.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block can accept a beat.
REQ-010 The block SHALL have port flush, input, 1 bit: pipeline flush; discards all held beats.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: the selected word at the head of the buffer.
REQ-012 The block SHALL have port out_err, output, 1 bit: the head beat had an out-of-range select.
REQ-013 The block SHALL have port out_valid, output, 1 bit: the head beat is valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts the head beat.
REQ-015 The block SHALL have port occupancy, output, 2 bits: the number of held beats (0..2).

Function
REQ-016 The block SHALL define accept as in_valid && in_ready && !flush, and deq as out_valid && out_ready && !flush.
REQ-017 At accept, the block SHALL capture word in_sel of in_data; if in_sel >= NUM_IN, it SHALL capture all-zero data with err=1, otherwise err=0.
REQ-018 Storage SHALL be a two-entry skid buffer (main, skid) tracked by a state machine with states EMPTY, HALF and FULL.
REQ-019 EMPTY SHALL drive out_valid=0, in_ready=1, occupancy=0; on accept: load main, go to HALF.
REQ-020 HALF SHALL drive out_valid=1, in_ready=1, occupancy=1, with transitions:
- accept && !deq: load skid, go to FULL.
- accept && deq: load main with the new beat, stay in HALF.
- deq only: go to EMPTY.
- neither: hold.
REQ-021 FULL SHALL drive out_valid=1, in_ready=0, occupancy=2; on deq: main<=skid, go to HALF; no accept is possible in FULL.
REQ-022 in_ready SHALL be a function of the state register only (no combinational path from out_ready or in_valid).
REQ-023 out_data and out_err SHALL come from the main register; latency SHALL be 1 cycle from accept to out_valid when EMPTY.
REQ-024 While out_valid=1 && out_ready=0, out_data and out_err SHALL be held stable.
REQ-025 Beat ordering SHALL be preserved; no beat SHALL be dropped or duplicated except by flush or reset.
REQ-026 flush=1 SHALL force the state to EMPTY at the next edge, regardless of in_valid or out_ready in that cycle; the concurrent beat SHALL NOT be accepted.
REQ-027 Data registers SHALL NOT be required to clear on flush; only the state and valid SHALL clear.

Reset
REQ-028 With reset=1 at a rising edge, the block SHALL enter EMPTY: out_valid=0, in_ready=1, occupancy=0, out_data=0, out_err=0.
REQ-029 Reset SHALL take priority over flush, accept and deq; a reset mid-transfer SHALL discard all held beats.

Verification (WIDTH=64, NUM_IN=4, in_data words {w0=5, w1=2, w2=10, w3=6})
REQ-030 The bench SHALL cover single beat: in_sel=2, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=10, out_err=0; the cycle after, out_valid=0.
REQ-031 The bench SHALL cover backpressure: out_ready=0 while beats sel=0 then sel=3 are sent -> occupancy 1 then 2, in_ready=0, out_data stays 5; then out_ready=1 -> outputs 5 then 6, and in_ready returns to 1.
REQ-032 The bench SHALL cover streaming: in_valid=1 and out_ready=1 continuously with sel cycling 0..3 -> one beat per cycle, outputs 5,2,10,6, occupancy stays 1.
REQ-033 The bench SHALL cover out-of-range select: NUM_IN=3, SEL_W=2, sel=3 -> out_data=0, out_err=1.
REQ-034 The bench SHALL cover flush: in FULL, assert flush together with in_valid=1 and out_ready=1 -> next cycle EMPTY, occupancy=0, out_valid=0, and no beat is emitted.
REQ-035 The bench SHALL cover reset mid-operation: in HALF holding 10, assert reset for 1 cycle -> out_valid=0, out_data=0, in_ready=1.

Source files
------------

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: selects one of NUM_IN words and queues it through a
// two-entry skid buffer so that in_ready is a pure function of state.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; empties the buffer and zeroes data
//   in_data    NUM_IN packed words, word k at [k*WIDTH +: WIDTH]
//   in_sel     index of the word to capture
//   in_valid   upstream beat present
//   in_ready   buffer has room (depends on state only)
//   flush      discards all held beats; the concurrent beat is dropped
//   out_data   selected word of the head beat
//   out_err    head beat had an out-of-range select (its data is zero)
//   out_valid  head beat present
//   out_ready  downstream accepts the head beat
//   occupancy  number of held beats, 0..2
module mux_n_pipe #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [1:0]              occupancy
);

  localparam int unsigned NUM_IN_U = NUM_IN;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_data_q, main_data_d;
  logic               main_err_q, main_err_d;
  logic [WIDTH-1:0]   skid_data_q, skid_data_d;
  logic               skid_err_q, skid_err_d;

  logic [WIDTH-1:0]   cap_data;
  logic               cap_err;
  logic               accept;
  logic               deq;

  // Word select; an index with no matching word yields zero data and err=1.
  always_comb begin
    cap_data = '0;
    cap_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN_U; k++) begin
      if (in_sel == SEL_W'(k)) begin
        cap_data = in_data[k*WIDTH +: WIDTH];
        cap_err  = 1'b0;
      end
    end
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    occupancy = 2'd0;
    case (state_q)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
      HALF: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      FULL: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        occupancy = 2'd2;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
      end
    endcase
  end

  assign accept = in_valid && in_ready && !flush;
  assign deq    = out_valid && out_ready && !flush;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_data_d = cap_data;
          main_err_d  = cap_err;
          state_d     = HALF;
        end
      end
      HALF: begin
        if (accept && !deq) begin
          skid_data_d = cap_data;
          skid_err_d  = cap_err;
          state_d     = FULL;
        end else if (accept && deq) begin
          // Head leaves this cycle, so the new beat becomes the head directly.
          main_data_d = cap_data;
          main_err_d  = cap_err;
        end else if (deq) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deq) begin
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
          state_d     = HALF;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only clears the state; data registers keep stale contents.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign out_data = main_data_q;
  assign out_err  = main_err_q;

endmodule
